// File: rtl/regfl_mp.sv
// regfl_mp - parametrised multi-port register file.
//
// W-bit words, N entries. One byte-enabled write port, two registered read
// ports with write-first bypass, a flat snapshot of every entry and a
// sequential clear engine that zeroes one entry per cycle.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous reset, active-high; overrides everything
//   we/wa/wd   : write enable, address, data
//   wbe        : byte enables, bit k covers wd[8k+7:8k]
//   ra0/ra1    : read addresses
//   rd0/rd1    : registered read data (0 for out-of-range addresses)
//   clr        : start a sequential clear (pulse is enough)
//   busy       : registered, high while the clear engine runs
//   q          : flat snapshot, q[i*W +: W] is entry i (straight from the entries)
module regfl_mp #(
    parameter int  W  = 64,
    parameter int  N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [W-1:0]     wd,
    input  logic [W/8-1:0]   wbe,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    output logic [W-1:0]     rd0,
    output logic [W-1:0]     rd1,
    input  logic             clr,
    output logic             busy,
    output logic [N*W-1:0]   q
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } state_t;

    localparam logic [AW:0]   N_EXT    = (AW+1)'(N);
    localparam logic [AW-1:0] PTR_LAST = AW'(N-1);

    state_t          state_r;
    state_t          state_n_s;
    logic [AW-1:0]   ptr_r;
    logic [AW-1:0]   ptr_n_s;
    logic [W-1:0]    mem_r [N];

    logic            wa_ok_s;
    logic            wr_accept_s;
    logic [W-1:0]    wr_old_s;
    logic [W-1:0]    wr_merged_s;
    logic [W-1:0]    rd0_cur_s;
    logic [W-1:0]    rd1_cur_s;
    logic [W-1:0]    rd0_n_s;
    logic [W-1:0]    rd1_n_s;

    // Address range check; N need not be a power of two.
    assign wa_ok_s = ({1'b0, wa} < N_EXT);

    // A write lands only in IDLE with no clear request in the same cycle.
    assign wr_accept_s = we && (state_r == ST_IDLE) && !clr && wa_ok_s;

    // Entry muxes: an address matching no entry (out of range) yields 0.
    always_comb begin
        wr_old_s  = {W{1'b0}};
        rd0_cur_s = {W{1'b0}};
        rd1_cur_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (wa == AW'(i)) begin
                wr_old_s = mem_r[i];
            end else begin
                wr_old_s = wr_old_s;
            end
            if (ra0 == AW'(i)) begin
                rd0_cur_s = mem_r[i];
            end else begin
                rd0_cur_s = rd0_cur_s;
            end
            if (ra1 == AW'(i)) begin
                rd1_cur_s = mem_r[i];
            end else begin
                rd1_cur_s = rd1_cur_s;
            end
        end
    end

    // Byte merge of the write data into the addressed entry's current value.
    always_comb begin
        wr_merged_s = wr_old_s;
        for (int k = 0; k < W/8; k++) begin
            if (wbe[k]) begin
                wr_merged_s[8*k +: 8] = wd[8*k +: 8];
            end else begin
                wr_merged_s[8*k +: 8] = wr_old_s[8*k +: 8];
            end
        end
    end

    // Next read data with write-first bypass; clearing is never bypassed,
    // so a read of the entry being cleared still sees its old contents.
    always_comb begin
        rd0_n_s = rd0_cur_s;
        rd1_n_s = rd1_cur_s;
        if (wr_accept_s && (wa == ra0)) begin
            rd0_n_s = wr_merged_s;
        end else begin
            rd0_n_s = rd0_cur_s;
        end
        if (wr_accept_s && (wa == ra1)) begin
            rd1_n_s = wr_merged_s;
        end else begin
            rd1_n_s = rd1_cur_s;
        end
    end

    // Clear engine next-state logic.
    always_comb begin
        state_n_s = state_r;
        ptr_n_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (clr) begin
                    state_n_s = ST_CLR;
                    ptr_n_s   = {AW{1'b0}};
                end else begin
                    state_n_s = ST_IDLE;
                    ptr_n_s   = ptr_r;
                end
            end
            ST_CLR: begin
                if (ptr_r == PTR_LAST) begin
                    state_n_s = ST_IDLE;
                    ptr_n_s   = {AW{1'b0}};
                end else begin
                    state_n_s = ST_CLR;
                    ptr_n_s   = ptr_r + AW'(1);
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                ptr_n_s   = {AW{1'b0}};
            end
        endcase
    end

    // Clear engine state and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_n_s;
            ptr_r   <= ptr_n_s;
        end
    end

    // Registered read ports and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0  <= {W{1'b0}};
            rd1  <= {W{1'b0}};
            busy <= 1'b0;
        end else begin
            rd0  <= rd0_n_s;
            rd1  <= rd1_n_s;
            busy <= (state_n_s == ST_CLR);
        end
    end

    // Entry storage: clear and write are mutually exclusive (writes need IDLE).
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                mem_r[i] <= {W{1'b0}};
            end else if ((state_r == ST_CLR) && (ptr_r == AW'(i))) begin
                mem_r[i] <= {W{1'b0}};
            end else if (wr_accept_s && (wa == AW'(i))) begin
                mem_r[i] <= wr_merged_s;
            end else begin
                mem_r[i] <= mem_r[i];
            end
        end
    end

    // Flat snapshot straight from the entry registers.
    for (genvar g = 0; g < N; g++) begin : g_snap
        assign q[g*W +: W] = mem_r[g];
    end

endmodule

// File: tb/tb_regfl_mp.sv
// Self-checking bench for regfl_mp: an N=8 and an N=6 instance share every
// input, and a behavioural model (arrays plus a remaining-clear counter) is
// compared against both after each clock edge.
module tb_regfl_mp;

    logic         clk = 1'b0;
    logic         rst, we, clr;
    logic [2:0]   wa, ra0, ra1;
    logic [63:0]  wd;
    logic [7:0]   wbe;
    logic [63:0]  rd0_a, rd1_a, rd0_b, rd1_b;
    logic         busy_a, busy_b;
    logic [511:0] q_a;
    logic [383:0] q_b;

    regfl_mp #(.W(64), .N(8)) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_a), .rd1(rd1_a),
        .clr(clr), .busy(busy_a), .q(q_a)
    );

    regfl_mp #(.W(64), .N(6)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_b), .rd1(rd1_b),
        .clr(clr), .busy(busy_b), .q(q_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: index 0 is the N=8 instance, index 1 the N=6 one.
    logic [63:0] mem  [2][8];
    int          rem  [2];
    logic [63:0] erd0 [2];
    logic [63:0] erd1 [2];

    function automatic int nent(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] dat,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int k = 0; k < 8; k++) if (be[k]) r[8*k +: 8] = dat[8*k +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict, clock, then compare both instances to the model.
    task automatic cycle();
        logic [63:0] nmem [2][8];
        int          nrem [2];
        logic [63:0] n0 [2];
        logic [63:0] n1 [2];
        logic [511:0] flat_a, flat_b;
        bit wok;
        int n;
        for (int d = 0; d < 2; d++) begin
            n = nent(d);
            for (int i = 0; i < 8; i++) nmem[d][i] = mem[d][i];
            if (rst) begin
                for (int i = 0; i < 8; i++) nmem[d][i] = 64'h0;
                nrem[d] = 0;
                n0[d] = 64'h0;
                n1[d] = 64'h0;
            end else begin
                wok = we && (rem[d] == 0) && !clr && (int'(wa) < n);
                if (int'(ra0) >= n) n0[d] = 64'h0;
                else if (wok && wa == ra0) n0[d] = merge(mem[d][wa], wd, wbe);
                else n0[d] = mem[d][ra0];
                if (int'(ra1) >= n) n1[d] = 64'h0;
                else if (wok && wa == ra1) n1[d] = merge(mem[d][wa], wd, wbe);
                else n1[d] = mem[d][ra1];
                if (rem[d] > 0) begin
                    nmem[d][n - rem[d]] = 64'h0;
                    nrem[d] = rem[d] - 1;
                end else if (clr) begin
                    nrem[d] = n;
                end else begin
                    nrem[d] = 0;
                end
                if (wok) nmem[d][wa] = merge(mem[d][wa], wd, wbe);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mem[d][i] = nmem[d][i];
            rem[d]  = nrem[d];
            erd0[d] = n0[d];
            erd1[d] = n1[d];
        end
        flat_a = '0;
        flat_b = '0;
        for (int i = 0; i < 8; i++) flat_a[i*64 +: 64] = mem[0][i];
        for (int i = 0; i < 6; i++) flat_b[i*64 +: 64] = mem[1][i];
        check("q_n8",    q_a,    flat_a);
        check("q_n6",    q_b,    flat_b);
        check("rd0_n8",  rd0_a,  erd0[0]);
        check("rd1_n8",  rd1_a,  erd1[0]);
        check("rd0_n6",  rd0_b,  erd0[1]);
        check("rd1_n6",  rd1_b,  erd1[1]);
        check("busy_n8", busy_a, (rem[0] > 0));
        check("busy_n6", busy_b, (rem[1] > 0));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we = 1'b0; clr = 1'b0;
        wa = 3'd0; wd = 64'h0; wbe = 8'h00; ra0 = 3'd0; ra1 = 3'd0;
    endtask

    task automatic write(input logic [2:0] a, input logic [63:0] dat, input logic [7:0] be);
        we = 1'b1; wa = a; wd = dat; wbe = be;
        cycle();
        we = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++)
            write(3'(i), {$urandom(), $urandom()} | 64'h1, 8'hFF);
    endtask

    int cnt_a, cnt_b;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mem[d][i] = 64'h0;
            rem[d] = 0; erd0[d] = 64'h0; erd1[d] = 64'h0;
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Reset after a full fill
        fill_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("reset_q",    q_a,    512'h0);
        check("reset_rd0",  rd0_a,  64'h0);
        check("reset_busy", busy_a, 1'b0);

        // Full write then read
        write(3'd5, 64'hDEADBEEF_01234567, 8'hFF);
        ra0 = 3'd5;
        cycle();
        check("wr_rd0",  rd0_a,          64'hDEADBEEF_01234567);
        check("wr_q5",   q_a[383:320],   64'hDEADBEEF_01234567);

        // Byte enables with bypass to rd1
        write(3'd2, 64'h1111_1111_1111_1111, 8'hFF);
        ra1 = 3'd2;
        write(3'd2, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        check("be_bypass_rd1", rd1_a, 64'h1111_1111_AAAA_AAAA);
        write(3'd2, 64'h5555_5555_5555_5555, 8'h00);
        check("be_zero_q2", q_a[191:128], 64'h1111_1111_AAAA_AAAA);

        // Clear with a dropped write during busy
        fill_all();
        clr = 1'b1;
        ra0 = 3'd3; ra1 = 3'd0;
        cycle();
        clr = 1'b0;
        cnt_a = int'(busy_a);
        cnt_b = int'(busy_b);
        for (int c = 0; c < 20; c++) begin
            we = (c < 4); wa = 3'd3; wd = 64'hFFFF_0000_FFFF_0000; wbe = 8'hFF;
            ra1 = 3'(c);
            cycle();
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
        end
        we = 1'b0;
        check("clr_busy_len_n8", cnt_a, 8);
        check("clr_busy_len_n6", cnt_b, 6);
        check("clr_final_q_n8",  q_a,   512'h0);

        // Reset in the middle of a clear, then an immediate write
        fill_all();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midclr_q",    q_a,    512'h0);
        check("midclr_busy", busy_a, 1'b0);
        write(3'd1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        check("midclr_wr", q_a[127:64], 64'h0123_4567_89AB_CDEF);

        // Out-of-range write and read on the N=6 instance
        fill_all();
        write(3'd7, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
        ra0 = 3'd6;
        cycle();
        check("oor_rd0_n6", rd0_b, 64'h0);

        // clr held high: back-to-back clears
        clr = 1'b1;
        for (int c = 0; c < 24; c++) cycle();
        clr = 1'b0;
        for (int c = 0; c < 10; c++) cycle();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            clr = ($urandom_range(0, 24) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wa  = 3'($urandom_range(0, 7));
            ra0 = 3'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
            wd  = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       wbe = 8'hFF;
                1:       wbe = 8'h00;
                default: wbe = 8'($urandom_range(0, 255));
            endcase
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfl_mp.md
# regfl_mp

Parametrised multi-port register file for the lab datapath. W-bit words, N entries, one byte-enabled write port, two registered read ports with write-first bypass, and a flat snapshot bus of all entries. It adds a sequential clear engine that zeroes all entries one per cycle and signals `busy` while it runs. It replaces fixed 8×64 register files wherever a CPU-style two-read/one-write array is needed.

## Interface
- `W`, 64: word width in bits; must be a multiple of 8.
- `N`, 8: number of entries, 2..256; need not be a power of two.
- `AW`: localparam, `$clog2(N)`, address width.
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `we`  in  1  write enable.
- `wa`  in  AW  write address.
- `wd`  in  W  write data.
- `wbe`  in  W/8  byte enables; bit k covers `wd[8k+7:8k]`.
- `ra0`, `ra1`  in  AW  read addresses.
- `rd0`, `rd1`  out  W  registered read data.
- `clr`  in  1  start sequential clear; a one-cycle pulse is sufficient.
- `busy`  out  1  clear engine active; registered.
- `q`  out  N*W  flat snapshot; `q[i*W +: W]` is entry i.

## Operation
- **Reset** (`rst`=1 at an edge) forces:
  - all entries to 0;
  - `rd0`, `rd1` to 0;
  - FSM to IDLE, clear pointer to 0;
  - `busy` to 0.
- **Reset priority:** `rst` overrides everything else, including an in-progress clear.
- **Write:** when `we`=1, `busy`=0 and `clr`=0, entry `wa` is updated at the edge. Only bytes with `wbe[k]`=1 change; the other bytes keep their value. `wbe`=0 performs no write.
- **Out-of-range write:** `wa` ≥ N is ignored and no entry changes.
- **Read:**
  - `rd0` is updated every cycle with entry `ra0`; `rd1` likewise with `ra1`.
  - Bypass: if a write is accepted in the same cycle and `wa`==`ra0`, `rd0` gets the post-write, byte-merged value. Same rule for `rd1`.
  - Out-of-range read: `ra` ≥ N returns 0.
- **Clear FSM.** Two states, IDLE and CLR.
  - IDLE→CLR when `clr`=1. The pointer loads 0. Any `we` in that same cycle is dropped (`clr` has priority).
  - In CLR: entry[ptr] is set to 0 at each edge and ptr increments. When ptr==N-1, that edge zeroes the last entry and returns the FSM to IDLE.
  - `clr` while in CLR is ignored.
  - `we` while in CLR is dropped, with no queuing and no error flag.
  - Reads while in CLR return current contents. Entries not yet cleared keep their data.
  - A read of the entry being cleared in that same cycle returns the pre-clear value (no bypass for clear).
- `busy` = (state==CLR).
- `q` reflects the entry registers directly, with no extra register stage.

## Timing
- Write-to-`q` latency: 1 edge.
- Read latency: 1 edge from address to `rd`. With bypass, data written at edge t is visible on `rd` after edge t.
- Clear, with `clr` sampled at edge t0:
  - `busy`=1 after t0;
  - entry i becomes 0 at edge t0+1+i;
  - `busy` falls at edge t0+N.
  - Total: N busy cycles. The first write accepted is at edge t0+N+1.
- **Back-to-back clear:** `clr` held high continuously restarts a new clear on the first IDLE cycle after `busy` falls.
- **Reset mid-clear:** all entries are 0 after the reset edge, and the FSM starts in IDLE with `busy`=0 on the next cycle.
- No combinational path from any input to any output except through the entry registers to `q`.

## Test plan
- **Reset:** write nonzero data to all 8 entries, assert `rst` for one edge. Then `q`=0, `rd0`=`rd1`=0 and `busy`=0 after that edge.
- **Write/read:** write `64'hDEADBEEF_01234567` to entry 5 with `wbe`=8'hFF, then set `ra0`=5. `rd0` shows the value one edge later, and `q[383:320]` matches.
- **Byte enable + bypass:**
  - Entry 2 holds `64'h1111_1111_1111_1111`.
  - Write `64'hAAAA_AAAA_AAAA_AAAA` with `wbe`=8'h0F, with `ra1`=2 in the same cycle.
  - `rd1`=`64'h1111_1111_AAAA_AAAA` after that edge.
- **Clear:** fill all entries with nonzero values, pulse `clr`, and assert `we` to entry 3 during busy.
  - `busy` stays high for exactly 8 cycles.
  - Entry i reads 0 from edge t0+1+i onward.
  - The write to entry 3 is lost, and final `q`=0.
- **Reset mid-clear:** assert `rst` at edge t0+3. All entries are 0 afterward, `busy`=0, and a write at the next cycle is accepted.
- **Out-of-range, N=6:**
  - Write to `wa`=7: `q` is unchanged.
  - Read `ra0`=6: `rd0`=0.
  - Clear of N=6: `busy` is high for exactly 6 cycles.
